// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: bundles the two handshakes of the instruction-fetch stage.
//   Memory side : imem_req/imem_addr out, imem_ack/imem_rdata back.
//   Decode side : ir_valid/ir_data/ir_pc out, ir_ready back.
// master = the fetch stage itself, slave = memory model plus decode consumer.
interface ifetch_queue_if;
  logic        imem_req;
  logic [31:2] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_data;
  logic [31:2] ir_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output ir_valid, ir_data, ir_pc,
    input  ir_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  ir_valid, ir_data, ir_pc,
    output ir_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch stage sitting right after the PC register.
// Fetches the word at PC with a single outstanding req/ack read, buffers the
// returned instruction together with its address in a DEPTH-entry circular
// queue, and presents the queue head to decode.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   PC         current fetch word address
//   pc_en      one-cycle pulse: current PC was fetched, PC register may advance
//   flush      redirect: drops queued entries and the in-flight fetch
//   bus        ifetch_queue_if.master (imem_* request side, ir_* decode side)
//   fsm_state  debug view of the fetch FSM (0 IDLE, 1 WAIT, 2 DROP)
//   fetch_cnt  (IFETCH_STATS_EN only) count of acks that were enqueued
//   drop_cnt   (IFETCH_STATS_EN only) count of acks discarded after a flush
//
// Optional feature: define IFETCH_STATS_EN to add the fetch_cnt/drop_cnt
// counters and ports. Without it the block behaves identically minus those.
//
// Handshakes: imem_req is a request that, once raised, holds together with
// imem_addr until the cycle imem_ack is high; that cycle completes it.
// ir_valid/ir_ready transfer the head entry on any cycle both are high;
// ir_ready while ir_valid is low has no effect.
module ifetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:2]   PC,
  output logic          pc_en,
  input  logic          flush,
  ifetch_queue_if.master bus,
`ifdef IFETCH_STATS_EN
  output logic [31:0]   fetch_cnt,
  output logic [31:0]   drop_cnt,
`endif
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  state_t state, state_next;

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;
  logic [31:0]      data_mem [DEPTH];
  logic [31:2]      pc_mem   [DEPTH];

  logic issue;     // launch a request this cycle
  logic enq;       // non-flushed ack: write into the queue
  logic deq;       // decode takes the head
  logic ack_drop;  // ack whose data is thrown away

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    enq        = 1'b0;
    ack_drop   = 1'b0;
    pc_en      = 1'b0;
    case (state)
      IDLE: begin
        // Fullness is only checked here; with one fetch in flight the
        // eventual enqueue is guaranteed a free slot.
        if (!flush && (count < FULL)) begin
          issue      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_ack) begin
          state_next = IDLE;
          if (flush) begin
            ack_drop = 1'b1;
          end else begin
            enq   = 1'b1;
            pc_en = 1'b1;
          end
        end else if (flush) begin
          // Request cannot be withdrawn, so wait for its ack and bin it.
          state_next = DROP;
        end
      end
      DROP: begin
        if (bus.imem_ack) begin
          ack_drop   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign fsm_state = state;

  // ------------------------------------------------------ request port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= '0;
    end else if (issue) begin
      bus.imem_req  <= 1'b1;
      bus.imem_addr <= PC;
    end else if ((state != IDLE) && bus.imem_ack) begin
      bus.imem_req  <= 1'b0;
    end
  end

  // -------------------------------------------------------------- queue
  assign deq          = bus.ir_valid && bus.ir_ready;
  assign bus.ir_valid = (count != '0);
  assign bus.ir_data  = data_mem[rd_ptr];
  assign bus.ir_pc    = pc_mem[rd_ptr];

  // Flush wins over a same-cycle enqueue or dequeue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (enq && !flush) begin
      data_mem[wr_ptr] <= bus.imem_rdata;
      pc_mem[wr_ptr]   <= bus.imem_addr;
    end
  end

`ifdef IFETCH_STATS_EN
  // ---------------------------------------------------------- counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (enq)      fetch_cnt <= fetch_cnt + 32'd1;
      if (ack_drop) drop_cnt  <= drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed bench for ifetch_queue (DEPTH=4).
// Inputs change on the falling edge; registered outputs are read on the
// falling edge and the combinational pc_en is read 1 time unit after the
// ack is driven.
module tb_ifetch_queue;
  localparam int W = 62;  // {ir_pc[29:0], ir_data[31:0]}

  logic        clk;
  logic        rst;
  logic [31:2] PC;
  logic        pc_en;
  logic        flush;
  logic [1:0]  fsm_state;
`ifdef IFETCH_STATS_EN
  logic [31:0] fetch_cnt;
  logic [31:0] drop_cnt;
`endif

  ifetch_queue_if bus ();

  ifetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .PC        (PC),
    .pc_en     (pc_en),
    .flush     (flush),
    .bus       (bus),
`ifdef IFETCH_STATS_EN
    .fetch_cnt (fetch_cnt),
    .drop_cnt  (drop_cnt),
`endif
    .fsm_state (fsm_state)
  );

  // ------------------------------------------------ clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int n_fetch;
  int n_drop;
  logic [W-1:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
  endfunction

  // --------------------------------------------------------- drivers
  task automatic do_reset(input logic [29:0] pc0);
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    bus.ir_ready = 1'b0;
    PC = pc0;
    exp_q.delete();
    n_fetch = 0;
    n_drop = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Advance falling edges until imem_req is seen (bounded).
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.imem_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Drive ack for one cycle starting at the current falling edge. The bench
  // decides whether this ack should enqueue; if so it records the expected
  // entry and advances its PC register model.
  task automatic ack_now(input bit enq, output logic pce);
    logic [29:0] a;
    a = bus.imem_addr;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = mem_word(a);
    #1;
    pce = pc_en;
    if (enq) begin
      exp_q.push_back({a, mem_word(a)});
      PC = PC + 30'd1;
      n_fetch++;
    end else begin
      n_drop++;
    end
    @(negedge clk);
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
  endtask

  // ------------------------------------------------------------ tests
  task automatic test_reset;
    bit ok;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 30'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.imem_addr); end
    checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL reset_pc_en got=%b exp=0", pc_en); end
    checks++; if (bus.ir_valid !== 1'b0) begin failures++; $display("FAIL reset_ir_valid got=%b exp=0", bus.ir_valid); end
    checks++; if (bus.ir_data !== 32'h0) begin failures++; $display("FAIL reset_ir_data got=%h exp=0", bus.ir_data); end
    checks++; if (bus.ir_pc !== 30'h0) begin failures++; $display("FAIL reset_ir_pc got=%h exp=0", bus.ir_pc); end
    checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
    // Reset asserted while a request is outstanding clears it at once.
    PC = 30'h0c00;
    rst = 1'b1;
    wait_req(ok);
    checks++; if (!ok) begin failures++; $display("FAIL reset_first_req got=timeout exp=req"); end
    rst = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_midfetch_req got=%b exp=0", bus.imem_req); end
    checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL reset_midfetch_state got=%0d exp=0", fsm_state); end
  endtask

  task automatic test_single_fetch;
    bit ok;
    logic pce;
    do_reset(30'h0c00);
    wait_req(ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_req got=timeout exp=req"); end
    checks++; if (bus.imem_addr !== 30'h0c00) begin failures++; $display("FAIL single_addr got=%h exp=%h", bus.imem_addr, 30'h0c00); end
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL single_req_hold got=%b exp=1", bus.imem_req); end
    ack_now(1'b1, pce);
    checks++; if (pce !== 1'b1) begin failures++; $display("FAIL single_pc_en got=%b exp=1", pce); end
    checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL single_pc_en_after got=%b exp=0", pc_en); end
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL single_req_drop got=%b exp=0", bus.imem_req); end
    checks++; if (bus.ir_valid !== 1'b1) begin failures++; $display("FAIL single_ir_valid got=%b exp=1", bus.ir_valid); end
    checks++; if (bus.ir_pc !== 30'h0c00) begin failures++; $display("FAIL single_ir_pc got=%h exp=%h", bus.ir_pc, 30'h0c00); end
    checks++; if (bus.ir_data !== mem_word(30'h0c00)) begin failures++; $display("FAIL single_ir_data got=%h exp=%h", bus.ir_data, mem_word(30'h0c00)); end
  endtask

  task automatic test_fill_drain;
    bit ok;
    logic pce;
    logic [W-1:0] e;
    do_reset(30'h0c00);
    for (int i = 0; i < 4; i++) begin
      wait_req(ok);
      checks++; if (!ok) begin failures++; $display("FAIL fill_req%0d got=timeout exp=req", i); end
      checks++; if (bus.imem_addr !== 30'h0c00 + 30'(i)) begin failures++; $display("FAIL fill_addr%0d got=%h exp=%h", i, bus.imem_addr, 30'h0c00 + 30'(i)); end
      ack_now(1'b1, pce);
      checks++; if (pce !== 1'b1) begin failures++; $display("FAIL fill_pc_en%0d got=%b exp=1", i, pce); end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL full_req_idle%0d got=%b exp=0", i, bus.imem_req); end
    end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++; if (bus.ir_valid !== 1'b1) begin failures++; $display("FAIL drain_valid%0d got=%b exp=1", i, bus.ir_valid); end
      checks++; if (bus.ir_pc !== e[61:32]) begin failures++; $display("FAIL drain_pc%0d got=%h exp=%h", i, bus.ir_pc, e[61:32]); end
      checks++; if (bus.ir_data !== e[31:0]) begin failures++; $display("FAIL drain_data%0d got=%h exp=%h", i, bus.ir_data, e[31:0]); end
      bus.ir_ready = 1'b1;
      @(negedge clk);
    end
    bus.ir_ready = 1'b0;
    checks++; if (bus.ir_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", bus.ir_valid); end
  endtask

  task automatic test_ack_delay;
    bit ok;
    logic pce;
    do_reset(30'h2000);
    wait_req(ok);
    checks++; if (!ok) begin failures++; $display("FAIL delay_req got=timeout exp=req"); end
    checks++; if (bus.imem_addr !== 30'h2000) begin failures++; $display("FAIL delay_addr got=%h exp=%h", bus.imem_addr, 30'h2000); end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL delay_req_hold%0d got=%b exp=1", i, bus.imem_req); end
      checks++; if (bus.imem_addr !== 30'h2000) begin failures++; $display("FAIL delay_addr_hold%0d got=%h exp=%h", i, bus.imem_addr, 30'h2000); end
      checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL delay_pc_en_early%0d got=%b exp=0", i, pc_en); end
    end
    ack_now(1'b1, pce);
    checks++; if (pce !== 1'b1) begin failures++; $display("FAIL delay_pc_en got=%b exp=1", pce); end
    checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL delay_pc_en_after got=%b exp=0", pc_en); end
    checks++; if (bus.ir_pc !== 30'h2000) begin failures++; $display("FAIL delay_ir_pc got=%h exp=%h", bus.ir_pc, 30'h2000); end
  endtask

  task automatic test_flush_wait;
    bit ok;
    logic pce;
    do_reset(30'h0c00);
    wait_req(ok);
    ack_now(1'b1, pce);
    wait_req(ok);
    checks++; if (bus.imem_addr !== 30'h0c01) begin failures++; $display("FAIL fw_addr got=%h exp=%h", bus.imem_addr, 30'h0c01); end
    flush = 1'b1;
    PC = 30'h1000;
    exp_q.delete();
    #1;
    checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL fw_pc_en_flush got=%b exp=0", pc_en); end
    @(negedge clk);
    flush = 1'b0;
    checks++; if (fsm_state !== 2'd2) begin failures++; $display("FAIL fw_state_drop got=%0d exp=2", fsm_state); end
    checks++; if (bus.ir_valid !== 1'b0) begin failures++; $display("FAIL fw_ir_valid got=%b exp=0", bus.ir_valid); end
    checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL fw_req_held got=%b exp=1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 30'h0c01) begin failures++; $display("FAIL fw_addr_held got=%h exp=%h", bus.imem_addr, 30'h0c01); end
    flush = 1'b1;  // a second flush while already dropping
    @(negedge clk);
    flush = 1'b0;
    checks++; if (fsm_state !== 2'd2) begin failures++; $display("FAIL fw_state_drop2 got=%0d exp=2", fsm_state); end
    checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL fw_req_held2 got=%b exp=1", bus.imem_req); end
    @(negedge clk);
    ack_now(1'b0, pce);
    checks++; if (pce !== 1'b0) begin failures++; $display("FAIL fw_pc_en_drop got=%b exp=0", pce); end
    checks++; if (bus.ir_valid !== 1'b0) begin failures++; $display("FAIL fw_ir_valid_after got=%b exp=0", bus.ir_valid); end
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL fw_req_released got=%b exp=0", bus.imem_req); end
    wait_req(ok);
    checks++; if (!ok) begin failures++; $display("FAIL fw_next_req got=timeout exp=req"); end
    checks++; if (bus.imem_addr !== 30'h1000) begin failures++; $display("FAIL fw_next_addr got=%h exp=%h", bus.imem_addr, 30'h1000); end
`ifdef IFETCH_STATS_EN
    checks++; if (fetch_cnt !== 32'(n_fetch)) begin failures++; $display("FAIL fw_fetch_cnt got=%0d exp=%0d", fetch_cnt, n_fetch); end
    checks++; if (drop_cnt !== 32'(n_drop)) begin failures++; $display("FAIL fw_drop_cnt got=%0d exp=%0d", drop_cnt, n_drop); end
`endif
  endtask

  task automatic test_flush_ack;
    bit ok;
    logic pce;
    do_reset(30'h0c00);
    for (int i = 0; i < 2; i++) begin
      wait_req(ok);
      ack_now(1'b1, pce);
    end
    wait_req(ok);
    checks++; if (bus.imem_addr !== 30'h0c02) begin failures++; $display("FAIL fa_addr got=%h exp=%h", bus.imem_addr, 30'h0c02); end
    checks++; if (bus.ir_valid !== 1'b1) begin failures++; $display("FAIL fa_valid_before got=%b exp=1", bus.ir_valid); end
    flush = 1'b1;
    exp_q.delete();
    ack_now(1'b0, pce);
    flush = 1'b0;
    checks++; if (pce !== 1'b0) begin failures++; $display("FAIL fa_pc_en got=%b exp=0", pce); end
    checks++; if (bus.ir_valid !== 1'b0) begin failures++; $display("FAIL fa_ir_valid got=%b exp=0", bus.ir_valid); end
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL fa_req got=%b exp=0", bus.imem_req); end
    wait_req(ok);
    checks++; if (!ok) begin failures++; $display("FAIL fa_next_req got=timeout exp=req"); end
    checks++; if (bus.imem_addr !== 30'h0c02) begin failures++; $display("FAIL fa_next_addr got=%h exp=%h", bus.imem_addr, 30'h0c02); end
`ifdef IFETCH_STATS_EN
    checks++; if (drop_cnt !== 32'(n_drop)) begin failures++; $display("FAIL fa_drop_cnt got=%0d exp=%0d", drop_cnt, n_drop); end
`endif
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic pce;
    logic [W-1:0] e;
    do_reset(30'h0c00);
    for (int i = 0; i < 2; i++) begin
      wait_req(ok);
      ack_now(1'b1, pce);
    end
    // Each ack coincides with a dequeue: occupancy stays 2 while the write
    // pointer goes 2,3,0,1,2 and the read pointer 0,1,2,3,0.
    for (int i = 0; i < 4; i++) begin
      wait_req(ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_req%0d got=timeout exp=req", i); end
      e = exp_q.pop_front();
      checks++; if (bus.ir_pc !== e[61:32]) begin failures++; $display("FAIL b2b_head_pc%0d got=%h exp=%h", i, bus.ir_pc, e[61:32]); end
      checks++; if (bus.ir_data !== e[31:0]) begin failures++; $display("FAIL b2b_head_data%0d got=%h exp=%h", i, bus.ir_data, e[31:0]); end
      bus.ir_ready = 1'b1;
      ack_now(1'b1, pce);
      bus.ir_ready = 1'b0;
      checks++; if (pce !== 1'b1) begin failures++; $display("FAIL b2b_pc_en%0d got=%b exp=1", i, pce); end
    end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      checks++; if (bus.ir_valid !== 1'b1) begin failures++; $display("FAIL b2b_drain_valid%0d got=%b exp=1", i, bus.ir_valid); end
      checks++; if (bus.ir_pc !== e[61:32]) begin failures++; $display("FAIL b2b_drain_pc%0d got=%h exp=%h", i, bus.ir_pc, e[61:32]); end
      checks++; if (bus.ir_data !== e[31:0]) begin failures++; $display("FAIL b2b_drain_data%0d got=%h exp=%h", i, bus.ir_data, e[31:0]); end
      bus.ir_ready = 1'b1;
      @(negedge clk);
    end
    bus.ir_ready = 1'b0;
    checks++; if (bus.ir_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", bus.ir_valid); end
`ifdef IFETCH_STATS_EN
    checks++; if (fetch_cnt !== 32'(n_fetch)) begin failures++; $display("FAIL b2b_fetch_cnt got=%0d exp=%0d", fetch_cnt, n_fetch); end
    checks++; if (drop_cnt !== 32'(n_drop)) begin failures++; $display("FAIL b2b_drop_cnt got=%0d exp=%0d", drop_cnt, n_drop); end
`endif
  endtask

  // ---------------------------------------------------------- sequence
  initial begin
    checks = 0;
    failures = 0;
    n_fetch = 0;
    n_drop = 0;
    rst = 1'b0;
    PC = '0;
    flush = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    bus.ir_ready = 1'b0;
    test_reset();
    test_single_fetch();
    test_fill_drain();
    test_ack_delay();
    test_flush_wait();
    test_flush_ack();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC register; consumes the current word address PC[31:2].
- Issues one word read to instruction memory over a req/ack handshake.
- Buffers returned instructions with their addresses in a DEPTH-entry queue feeding decode through valid/ready.
- Pulses pc_en to advance the PC register once the current PC is fetched; flush discards queued and in-flight fetches on a redirect.

Parameters:
- DEPTH, 4, queue entries; power of 2, ≥2.
- PTR_W, 2, log2(DEPTH); must match DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- PC  input  [31:2]  current fetch word address from the PC register.
- pc_en  output  1  one-cycle pulse: PC fetched, PC register may load NPC.
- flush  input  1  redirect/branch: drop queue and in-flight fetch.
- imem_req  output  1  memory read request.
- imem_addr  output  [31:2]  request word address.
- imem_ack  input  1  read data valid; completes the request.
- imem_rdata  input  32  instruction word.
- ir_valid  output  1  queue head valid.
- ir_ready  input  1  decode accepts head.
- ir_data  output  32  head instruction.
- ir_pc  output  [31:2]  head address.

Behaviour:
- Reset (rst=0, async): state IDLE; queue empty; imem_req=0, imem_addr=0, pc_en=0, ir_valid=0, ir_data=0, ir_pc=0.
- FSM states: IDLE, WAIT, DROP. At most one request is outstanding.
- IDLE:
  - If !flush and count<DEPTH: next cycle imem_req=1, imem_addr=PC (registered); go WAIT.
  - Otherwise stay in IDLE with imem_req=0.
- WAIT:
  - imem_req and imem_addr hold stable until imem_ack.
  - ack && !flush: enqueue {imem_addr, imem_rdata}; pc_en=1 for exactly that cycle; imem_req=0 next cycle; go IDLE.
  - ack && flush: data discarded, pc_en=0, go IDLE.
  - !ack && flush: go DROP.
- DROP:
  - imem_req stays 1 and the address is unchanged; no request is ever withdrawn.
  - On ack: discard data, no pc_en, go IDLE.
  - Further flush pulses in DROP have no additional effect.
- Throughput: at most one fetch per 2 cycles. Minimum latency PC→enqueue is 1 cycle after req assertion (ack may arrive in the first req cycle).
- Queue:
  - Circular buffer with PTR_W-bit read/write pointers and a (PTR_W+1)-bit count.
  - ir_valid = (count!=0); ir_data/ir_pc show the head entry.
  - Dequeue when ir_valid && ir_ready.
  - Enqueue and dequeue in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap DEPTH-1→0.
  - count<DEPTH is checked at request issue; since only one fetch is outstanding, an enqueue always finds a free slot.
- Flush:
  - Next cycle: count=0, pointers=0, ir_valid=0.
  - Flush overrides a simultaneous enqueue or dequeue; a dequeue on a flush cycle is still considered accepted by decode.
- pc_en is asserted only on a non-flushed ack; never in IDLE or DROP.
- Reset mid-fetch: all state clears immediately. Memory must tolerate req dropping without ack on reset.
- ir_ready while ir_valid=0 is ignored.

Optional Feature:
- Macro: IFETCH_STATS_EN.
- Defined: adds output ports fetch_cnt[31:0] (non-flushed acks) and drop_cnt[31:0] (acks discarded in WAIT-with-flush or DROP).
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, PC=30'h0c00, ack one cycle after req → imem_addr=30'h0c00, pc_en pulse 1 cycle, then ir_valid=1, ir_pc=30'h0c00, ir_data=memory word.
- ir_ready=0, ack every request, PC advancing +1 → exactly 4 entries queued (DEPTH=4), imem_req stays 0 while full; ir_ready=1 drains in order 0c00..0c03.
- Memory ack delayed 5 cycles → imem_req/imem_addr constant for all 5 cycles; a single pc_en on the ack cycle.
- Flush while WAIT and ack 3 cycles later → DROP, req held, data discarded, no pc_en, ir_valid=0; next request uses new PC=30'h1000.
- Flush and ack in the same cycle with 2 entries queued → queue empty next cycle, no pc_en, next fetch addr = current PC.
- Simultaneous enqueue and dequeue at count=2 across pointer wrap → count stays 2, ordering preserved; with IFETCH_STATS_EN, fetch_cnt/drop_cnt match the acks counted by the bench.
